// File: rtl/tmds_pkg.sv
// ============================================================================
// Module      : tmds_pkg
// Description : Constants shared by the TMDS encoder and decoder: the four
//               control-period tokens and the running-disparity width.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tmds_pkg;

  // Running disparity counter width (signed)
  localparam int CNT_W = 5;

  // Control-period tokens, indexed by {C1,C0}
  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  // Map a {C1,C0} pair to its control token
  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    case (c)
      2'b00:   tok = CTRL_TOKEN_00;
      2'b01:   tok = CTRL_TOKEN_01;
      2'b10:   tok = CTRL_TOKEN_10;
      default: tok = CTRL_TOKEN_11;
    endcase
    return tok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_popcount8.sv
// ============================================================================
// Module      : tmds_popcount8
// Description : Combinational count of the ones in an 8-bit word (0..8).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_popcount8 (
  input  logic [7:0] data_i,
  output logic [3:0] count_o
);

  // Sum every bit into a 4-bit accumulator
  always_comb begin
    count_o = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count_o = count_o + {3'd0, data_i[i]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/tmds_encoder.sv
// ============================================================================
// Module      : tmds_encoder
// Description : DVI 1.0 TMDS 8b/10b encoder, two-stage pipeline, 2 clk
//               latency, one input accepted every cycle.
//               Optional macro TMDS_ENCODER_DISP_OUT_EN adds the signed
//               running-disparity output 'disp', aligned with 'tmds'.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_encoder
  import tmds_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    de,
  input  logic [1:0]              ctrl,
  input  logic [7:0]              idata,
  output logic [9:0]              tmds
`ifdef TMDS_ENCODER_DISP_OUT_EN
  ,
  output logic signed [CNT_W-1:0] disp
`endif
);

  // ---------------------------------------------------------------- stage 1
  logic [3:0]  n1_idata;
  logic        use_xnor;
  logic [8:0]  qm_d;
  logic [3:0]  n1_qm_d;

  logic        de_q;
  logic [1:0]  ctrl_q;
  logic [8:0]  qm_q;
  logic [3:0]  n1_q;

  tmds_popcount8 u_pop_idata (
    .data_i  (idata),
    .count_o (n1_idata)
  );

  // Transition minimisation: chain XOR or XNOR, whichever yields fewer edges
  always_comb begin
    use_xnor = (n1_idata > 4'd4) || ((n1_idata == 4'd4) && !idata[0]);
    qm_d     = 9'd0;
    qm_d[0]  = idata[0];
    for (int i = 1; i < 8; i++) begin
      qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ idata[i]) : (qm_d[i-1] ^ idata[i]);
    end
    qm_d[8]  = ~use_xnor;
  end

  tmds_popcount8 u_pop_qm (
    .data_i  (qm_d[7:0]),
    .count_o (n1_qm_d)
  );

  // Stage-1 pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
      qm_q   <= 9'd0;
      n1_q   <= 4'd0;
    end else begin
      de_q   <= de;
      ctrl_q <= ctrl;
      qm_q   <= qm_d;
      n1_q   <= n1_qm_d;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic signed [CNT_W-1:0] cnt_q;
  logic signed [CNT_W-1:0] cnt_d;
  logic signed [CNT_W-1:0] diff;   // N1 - N0 of q_m[7:0]
  logic [9:0]              tmds_d;

  // DC balancing: choose inversion from the running disparity and update it
  always_comb begin
    // 2*N1 - 8 computed modulo 2^CNT_W; the true range -8..8 fits
    diff   = $signed({n1_q, 1'b0}) - 5'sd8;
    tmds_d = ctrl_token(ctrl_q);
    cnt_d  = '0;
    if (de_q) begin
      if ((cnt_q == 5'sd0) || (n1_q == 4'd4)) begin
        tmds_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
        cnt_d  = cnt_q + (qm_q[8] ? diff : -diff);
      end else if (((cnt_q > 5'sd0) && (n1_q > 4'd4)) ||
                   ((cnt_q < 5'sd0) && (n1_q < 4'd4))) begin
        tmds_d = {1'b1, qm_q[8], ~qm_q[7:0]};
        cnt_d  = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        tmds_d = {1'b0, qm_q[8], qm_q[7:0]};
        cnt_d  = cnt_q + diff - (qm_q[8] ? 5'sd0 : 5'sd2);
      end
    end
  end

  // Stage-2 output word and running disparity
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmds  <= CTRL_TOKEN_00;
      cnt_q <= '0;
    end else begin
      tmds  <= tmds_d;
      cnt_q <= cnt_d;
    end
  end

`ifdef TMDS_ENCODER_DISP_OUT_EN
  assign disp = cnt_q;
`endif

endmodule

`default_nettype wire

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 The block SHALL have no parameters; every width is fixed by the DVI 1.0 TMDS definition.
REQ-002 The block SHALL use clk as its clock and rst as its reset: asynchronous, active-high.
REQ-003 Port clk  input  1  pixel clock.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port de  input  1  data enable: 1 = video data, 0 = control period.
REQ-006 Port ctrl  input  2  control bits {C1,C0}, used when de=0.
REQ-007 Port idata  input  8  pixel component, used when de=1.
REQ-008 Port tmds  output  10  encoded word, registered; bit 0 is transmitted first.

Function
REQ-009 The block SHALL be a two-stage pipeline with 2 clk latency from the de/ctrl/idata sample to the tmds word, accepting one input every cycle.
REQ-010 Stage 1 SHALL register de, ctrl, q_m[8:0] and N1(q_m[7:0]).
REQ-011 Minimisation rule: if N1(idata)>4, or N1(idata)==4 with idata[0]==0, use XNOR chaining with q_m[8]=0; otherwise use XOR chaining with q_m[8]=1. q_m[0]=idata[0] in both cases.
REQ-012 Stage 2 SHALL hold a 5-bit signed running disparity cnt; N1/N0 below count q_m[7:0].
REQ-013 Case A (cnt==0 or N1==N0): tmds={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}.
- cnt += q_m[8] ? (N1-N0) : (N0-N1).
REQ-014 Case B ((cnt>0 and N1>N0) or (cnt<0 and N0>N1)): tmds={1, q_m[8], ~q_m[7:0]}.
- cnt += 2*q_m[8] + (N0-N1).
REQ-015 Case C (otherwise): tmds={0, q_m[8], q_m[7:0]}.
- cnt += (N1-N0) - 2*(~q_m[8]).
REQ-016 When the stage-2 de is 0, tmds SHALL be the control token for ctrl: 00->10'b1101010100, 01->10'b0010101011, 10->10'b0101010100, 11->10'b1010101011; cnt SHALL be cleared to 0 that cycle.
REQ-017 Invariant: cnt SHALL equal the running (ones minus zeros) of all tmds words emitted since the last control token; the 5-bit width SHALL never overflow.
REQ-018 de toggling every cycle SHALL be handled with no bubble or skipped word.

Reset
REQ-019 On rst: tmds=10'b1101010100, cnt=0, all stage-1 registers zero (de=0, ctrl=00). Reset applies immediately and asynchronously, including mid-run.
REQ-020 After rst deassert, the first two outputs SHALL be control tokens derived from the pipeline reset contents and the first sampled input, with no X values.

Configuration
REQ-021 Macro TMDS_ENCODER_DISP_OUT_EN, when defined, SHALL add output port disp  output  5  (signed cnt after the current word's update, aligned with tmds); when undefined the port and its logic SHALL be absent and behaviour otherwise identical.

Structure
REQ-022 A shared package tmds_pkg SHALL hold the four control-token constants (shared with the decoder) and the cnt width constant.
REQ-023 A sub-module tmds_popcount8 (8-bit ones count, 4-bit result) SHALL be instantiated for N1(idata) and N1(q_m[7:0]).

Verification
REQ-024 Reset asserted -> tmds=0x354; deassert with de=0, ctrl=01 -> tmds=0x0AB two cycles after ctrl is applied.
REQ-025 de=1, idata=0x00 twice from cnt=0 -> tmds 0x100 then 0x3FF; cnt -8 then +2.
REQ-026 de=1 for one cycle (idata=0xFF) between de=0 runs -> exactly one data word, then the ctrl token, and cnt returns to 0.
REQ-027 All 256 idata values, then 10000 random de/ctrl/idata words, looped through tmds_decoder -> de, ctrl and data match the inputs delayed by encoder latency plus one; the REQ-017 invariant is checked every cycle against disp (macro defined).
REQ-028 rst pulsed mid data run -> tmds=0x354 immediately and cnt=0; the next data word is encoded as from cnt=0.
